// File: rtl/shading_unit.sv
// Shading stage: round-robin arbitration over traversal-unit hits, base colour lookup,
// per-face brightness scaling and screen-buffer writes with frame-complete flag.
// hit_norm per port is {x,y,z}, each a signed 16-bit value with 8 fractional bits.
module shading_unit #(
  parameter int NUM_VTU      = 1,
  parameter int FRAME_AREA   = 76800,
  parameter int TOTAL_PIXELS = FRAME_AREA
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    frame_start,
  input  logic [NUM_VTU-1:0]                      hit_valid,
  output logic [NUM_VTU-1:0]                      hit_ready,
  input  logic [NUM_VTU*3-1:0]                    hit_type,
  input  logic [NUM_VTU*48-1:0]                   hit_norm,
  input  logic [NUM_VTU*$clog2(FRAME_AREA)-1:0]   hit_addr,
  output logic [15:0]                             sbuf_data,
  output logic [$clog2(FRAME_AREA)-1:0]           sbuf_addr,
  output logic                                    sbuf_write_enable,
  output logic                                    shade_done
);
  localparam int TYPE_W = 3;
  localparam int NORM_W = 48;
  localparam int ADDR_W = $clog2(FRAME_AREA);
  localparam int PTR_W  = (NUM_VTU > 1) ? $clog2(NUM_VTU) : 1;
  localparam int CNT_W  = $clog2(TOTAL_PIXELS + 1);

  localparam logic [TYPE_W-1:0] T_AIR        = 3'd0;
  localparam logic [TYPE_W-1:0] T_WATER      = 3'd1;
  localparam logic [TYPE_W-1:0] T_GRASS      = 3'd2;
  localparam logic [TYPE_W-1:0] T_DIRT       = 3'd3;
  localparam logic [TYPE_W-1:0] T_OAK_LOG    = 3'd4;
  localparam logic [TYPE_W-1:0] T_OAK_LEAVES = 3'd5;

  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  pick_lo_s, pick_hi_s, grant_idx_s;
  logic              found_hi_s, grant_ok_s;
  logic [NUM_VTU-1:0] hit_ready_s;
  logic [TYPE_W-1:0] sel_type_s;
  logic [NORM_W-1:0] sel_norm_s;
  logic [ADDR_W-1:0] sel_addr_s;

  logic              s1_valid_r, s2_valid_r;
  logic [TYPE_W-1:0] s1_type_r;
  logic [NORM_W-1:0] s1_norm_r;
  logic [ADDR_W-1:0] s1_addr_r, s2_addr_r;
  logic [4:0]        s2_r_r, s2_b_r;
  logic [5:0]        s2_g_r;
  logic [15:0]       base_s;
  logic [8:0]        factor_s;
  logic [4:0]        shade_r_s, shade_b_s;
  logic [5:0]        shade_g_s;

  logic [15:0]       sbuf_data_r;
  logic [ADDR_W-1:0] sbuf_addr_r;
  logic              sbuf_we_r, done_r;
  logic [CNT_W-1:0]  cnt_r;

  // Round-robin grant: lowest valid port at/after the pointer, else lowest valid overall (wrap)
  always_comb begin
    pick_lo_s  = '0;
    pick_hi_s  = '0;
    found_hi_s = 1'b0;
    sel_type_s = '0;
    sel_norm_s = '0;
    sel_addr_s = '0;
    for (int i = NUM_VTU - 1; i >= 0; i--) begin
      pick_lo_s  = hit_valid[i] ? PTR_W'(i) : pick_lo_s;
      pick_hi_s  = (hit_valid[i] && (PTR_W'(i) >= ptr_r)) ? PTR_W'(i) : pick_hi_s;
      found_hi_s = found_hi_s | (hit_valid[i] && (PTR_W'(i) >= ptr_r));
    end
    grant_idx_s = found_hi_s ? pick_hi_s : pick_lo_s;
    grant_ok_s  = rst_in && !frame_start && (|hit_valid);
    hit_ready_s = grant_ok_s ? (NUM_VTU'(1) << grant_idx_s) : '0;
    for (int i = 0; i < NUM_VTU; i++) begin
      sel_type_s = (grant_idx_s == PTR_W'(i)) ? hit_type[i*TYPE_W +: TYPE_W] : sel_type_s;
      sel_norm_s = (grant_idx_s == PTR_W'(i)) ? hit_norm[i*NORM_W +: NORM_W] : sel_norm_s;
      sel_addr_s = (grant_idx_s == PTR_W'(i)) ? hit_addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
    end
  end

  // Base colour lookup and face brightness factor from the registered hit
  always_comb begin
    base_s   = 16'h522A;
    factor_s = 9'd256;
    case (s1_type_r)
      T_AIR:        base_s = 16'hAE5D;
      T_WATER:      base_s = 16'h3211;
      T_GRASS:      base_s = 16'h5C29;
      T_DIRT:       base_s = 16'h8309;
      T_OAK_LOG:    base_s = 16'h59C5;
      T_OAK_LEAVES: base_s = 16'h852E;
      default:      base_s = 16'h522A;
    endcase
    if (s1_type_r == T_AIR) begin
      factor_s = 9'd256;
    end else if (!s1_norm_r[31] && (s1_norm_r[31:16] != 16'd0)) begin
      factor_s = 9'd256;
    end else if (s1_norm_r[31]) begin
      factor_s = 9'd128;
    end else if (s1_norm_r[47:32] != 16'd0) begin
      factor_s = 9'd204;
    end else if (s1_norm_r[15:0] != 16'd0) begin
      factor_s = 9'd153;
    end else begin
      factor_s = 9'd256;
    end
    shade_r_s = 5'((15'(base_s[15:11]) * 15'(factor_s)) >> 8);
    shade_g_s = 6'((15'(base_s[10:5])  * 15'(factor_s)) >> 8);
    shade_b_s = 5'((15'(base_s[4:0])   * 15'(factor_s)) >> 8);
  end

  // Arbitration pointer
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr_r <= '0;
    end else if (frame_start) begin
      ptr_r <= '0;
    end else if (grant_ok_s) begin
      ptr_r <= (grant_idx_s == PTR_W'(NUM_VTU - 1)) ? '0 : grant_idx_s + PTR_W'(1);
    end
  end

  // Three-stage shading pipeline; frame_start flushes every stage
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid_r  <= 1'b0;
      s1_type_r   <= '0;
      s1_norm_r   <= '0;
      s1_addr_r   <= '0;
      s2_valid_r  <= 1'b0;
      s2_r_r      <= '0;
      s2_g_r      <= '0;
      s2_b_r      <= '0;
      s2_addr_r   <= '0;
      sbuf_we_r   <= 1'b0;
      sbuf_data_r <= '0;
      sbuf_addr_r <= '0;
    end else begin
      s1_valid_r <= grant_ok_s;
      s2_valid_r <= s1_valid_r && !frame_start;
      sbuf_we_r  <= s2_valid_r && !frame_start;
      if (grant_ok_s) begin
        s1_type_r <= sel_type_s;
        s1_norm_r <= sel_norm_s;
        s1_addr_r <= sel_addr_s;
      end
      if (s1_valid_r) begin
        s2_r_r    <= shade_r_s;
        s2_g_r    <= shade_g_s;
        s2_b_r    <= shade_b_s;
        s2_addr_r <= s1_addr_r;
      end
      if (s2_valid_r && !frame_start) begin
        sbuf_data_r <= {s2_r_r, s2_g_r, s2_b_r};
        sbuf_addr_r <= s2_addr_r;
      end
    end
  end

  // Saturating write counter and sticky frame-complete flag
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else if (frame_start) begin
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else begin
      if (sbuf_we_r && (cnt_r < CNT_W'(TOTAL_PIXELS))) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (sbuf_we_r && (cnt_r == CNT_W'(TOTAL_PIXELS - 1))) begin
        done_r <= 1'b1;
      end
    end
  end

  assign hit_ready         = hit_ready_s;
  assign sbuf_data         = sbuf_data_r;
  assign sbuf_addr         = sbuf_addr_r;
  assign sbuf_write_enable = sbuf_we_r;
  assign shade_done        = done_r;
endmodule

// File: tb/tb_shading_unit.sv
// Directed self-checking bench for shading_unit with three ports and a four-pixel frame.
module tb_shading_unit;
  localparam int NV = 3;
  localparam logic [15:0] P1 = 16'h0100;
  localparam logic [15:0] N1 = 16'hFF00;
  localparam logic [15:0] Z0 = 16'h0000;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        frame_start;
  logic [NV-1:0]    hit_valid;
  logic [NV-1:0]    hit_ready;
  logic [NV*3-1:0]  hit_type;
  logic [NV*48-1:0] hit_norm;
  logic [NV*6-1:0]  hit_addr;
  logic [15:0] sbuf_data;
  logic [5:0]  sbuf_addr;
  logic        sbuf_write_enable;
  logic        shade_done;

  int errors = 0;
  int checks = 0;

  logic [2:0]  rr_type [3] = '{3'd2, 3'd1, 3'd3};
  logic [15:0] rr_col  [3] = '{16'h5C29, 16'h3211, 16'h8309};

  shading_unit #(.NUM_VTU(NV), .FRAME_AREA(64), .TOTAL_PIXELS(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_type(hit_type),
    .hit_norm(hit_norm), .hit_addr(hit_addr), .sbuf_data(sbuf_data),
    .sbuf_addr(sbuf_addr), .sbuf_write_enable(sbuf_write_enable),
    .shade_done(shade_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [2:0] t,
                          input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                          input logic [5:0] a);
    hit_valid[p]         = v;
    hit_type[p*3 +: 3]   = t;
    hit_norm[p*48 +: 48] = {x, y, z};
    hit_addr[p*6 +: 6]   = a;
  endtask

  task automatic clear_ports();
    hit_valid = '0;
    hit_type  = '0;
    hit_norm  = '0;
    hit_addr  = '0;
  endtask

  // One hit on port 0, then confirm the write lands exactly three cycles later
  task automatic shade_one(input string tag, input logic [2:0] t, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] z,
                           input logic [5:0] a, input logic [15:0] exp);
    clear_ports();
    set_port(0, 1'b1, t, x, y, z, a);
    @(negedge clk_in);
    check({tag, ".ready"}, 32'(hit_ready), 32'h1);
    tick();
    clear_ports();
    @(negedge clk_in);
    check({tag, ".we1"}, 32'(sbuf_write_enable), 32'h0);
    tick();
    @(negedge clk_in);
    check({tag, ".we2"}, 32'(sbuf_write_enable), 32'h0);
    tick();
    @(negedge clk_in);
    check({tag, ".we3"}, 32'(sbuf_write_enable), 32'h1);
    check({tag, ".data"}, 32'(sbuf_data), 32'(exp));
    check({tag, ".addr"}, 32'(sbuf_addr), 32'(a));
    tick();
    @(negedge clk_in);
    check({tag, ".we4"}, 32'(sbuf_write_enable), 32'h0);
    check({tag, ".hold"}, 32'(sbuf_data), 32'(exp));
    tick();
  endtask

  initial begin
    rst_in      = 1'b0;
    frame_start = 1'b0;
    clear_ports();
    set_port(0, 1'b1, 3'd2, Z0, P1, Z0, 6'd1);
    #12;
    check("rst.we",    32'(sbuf_write_enable), 32'h0);
    check("rst.data",  32'(sbuf_data), 32'h0);
    check("rst.addr",  32'(sbuf_addr), 32'h0);
    check("rst.done",  32'(shade_done), 32'h0);
    check("rst.ready", 32'(hit_ready), 32'h0);
    tick();
    rst_in = 1'b1;

    shade_one("grass_up",   3'd2, Z0, P1, Z0, 6'd5,  16'h5C29);
    shade_one("grass_down", 3'd2, Z0, N1, Z0, 6'd6,  16'h2A04);
    shade_one("grass_x",    3'd2, P1, Z0, Z0, 6'd7,  16'h4347);
    shade_one("air_x",      3'd0, P1, Z0, Z0, 6'd8,  16'hAE5D);
    shade_one("grass_z",    3'd2, Z0, Z0, N1, 6'd9,  16'h3265);
    shade_one("dirt_down",  3'd3, Z0, N1, Z0, 6'd10, 16'h4184);
    shade_one("other_zero", 3'd7, Z0, Z0, Z0, 6'd11, 16'h522A);
    shade_one("water_up",   3'd1, Z0, P1, Z0, 6'd12, 16'h3211);

    // Two pixels in flight when frame_start arrives
    clear_ports();
    set_port(0, 1'b1, 3'd2, Z0, P1, Z0, 6'd20);
    @(negedge clk_in);
    check("fs.done_before", 32'(shade_done), 32'h1);
    tick();
    set_port(0, 1'b1, 3'd2, Z0, P1, Z0, 6'd21);
    tick();
    frame_start = 1'b1;
    @(negedge clk_in);
    check("fs.ready", 32'(hit_ready), 32'h0);
    tick();
    frame_start = 1'b0;
    clear_ports();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check($sformatf("fs.we%0d", k), 32'(sbuf_write_enable), 32'h0);
      check($sformatf("fs.done%0d", k), 32'(shade_done), 32'h0);
      tick();
    end

    // All ports valid for six cycles: grants rotate from port 0, done after 4th write
    for (int t = 0; t < 10; t++) begin
      clear_ports();
      if (t < 6) begin
        for (int p = 0; p < NV; p++) set_port(p, 1'b1, rr_type[p], Z0, P1, Z0, 6'(32 + t));
      end
      @(negedge clk_in);
      if (t < 6) check($sformatf("rr.ready%0d", t), 32'(hit_ready), 32'(1 << (t % 3)));
      if (t >= 3 && t < 9) begin
        check($sformatf("rr.we%0d", t), 32'(sbuf_write_enable), 32'h1);
        check($sformatf("rr.addr%0d", t), 32'(sbuf_addr), 32'(32 + t - 3));
        check($sformatf("rr.data%0d", t), 32'(sbuf_data), 32'(rr_col[(t - 3) % 3]));
      end else begin
        check($sformatf("rr.we%0d", t), 32'(sbuf_write_enable), 32'h0);
      end
      check($sformatf("rr.done%0d", t), 32'(shade_done), 32'(t >= 7));
      tick();
    end

    // Asynchronous reset mid-stream with pointer parked at 2
    clear_ports();
    for (int p = 0; p < NV; p++) set_port(p, 1'b1, 3'd2, Z0, N1, Z0, 6'd50);
    tick();
    tick();
    clear_ports();
    tick();
    #1;
    check("ar.we_before", 32'(sbuf_write_enable), 32'h1);
    for (int p = 0; p < NV; p++) set_port(p, 1'b1, 3'd2, Z0, N1, Z0, 6'd55);
    #1;
    rst_in = 1'b0;
    #1;
    check("ar.we",    32'(sbuf_write_enable), 32'h0);
    check("ar.data",  32'(sbuf_data), 32'h0);
    check("ar.addr",  32'(sbuf_addr), 32'h0);
    check("ar.done",  32'(shade_done), 32'h0);
    check("ar.ready", 32'(hit_ready), 32'h0);
    tick();
    tick();
    rst_in = 1'b1;
    set_port(0, 1'b1, 3'd2, P1, Z0, Z0, 6'd61);
    @(negedge clk_in);
    check("ar.ready_after", 32'(hit_ready), 32'h1);
    check("ar.we0", 32'(sbuf_write_enable), 32'h0);
    tick();
    clear_ports();
    @(negedge clk_in);
    check("ar.we1", 32'(sbuf_write_enable), 32'h0);
    tick();
    @(negedge clk_in);
    check("ar.we2", 32'(sbuf_write_enable), 32'h0);
    tick();
    @(negedge clk_in);
    check("ar.we3",   32'(sbuf_write_enable), 32'h1);
    check("ar.data3", 32'(sbuf_data), 32'h4347);
    check("ar.addr3", 32'(sbuf_addr), 32'd61);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
